// File: rtl/can_pkg.sv
// Shared CAN frame definitions: Tx FIFO word field map, frame struct, fetch FSM states.
package can_pkg;

  localparam int unsigned CAN_FRAME_W = 128;
  localparam int unsigned ID_W        = 29;
  localparam int unsigned ID_LSB      = 99;
  localparam int unsigned IDE_BIT     = 98;
  localparam int unsigned RTR_BIT     = 97;
  localparam int unsigned DLC_W       = 4;
  localparam int unsigned DLC_LSB     = 93;
  localparam int unsigned RSVD_W      = 29;
  localparam int unsigned RSVD_LSB    = 64;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned DATA_LSB    = 0;
  localparam int unsigned DLC_MAX     = 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              ide;
    logic              rtr;
    logic [DLC_W-1:0]  dlc;
    logic [RSVD_W-1:0] rsvd;
    logic [DATA_W-1:0] data;
  } can_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_CAPTURE,
    ST_OFFER,
    ST_WAIT_DONE
  } tx_fetch_state_t;

endpackage

// File: rtl/can_frame_unpack.sv
// Combinational unpack of one 128-bit FIFO word into CAN fields, DLC clamped to 8.
module can_frame_unpack
  import can_pkg::*;
(
  input  logic [CAN_FRAME_W-1:0] word_i,
  output can_frame_t             frame_o
);

  // Slice the fixed field map; codes 9..15 mean 8 payload bytes on the wire.
  always_comb begin
    frame_o.id   = word_i[ID_LSB +: ID_W];
    frame_o.ide  = word_i[IDE_BIT];
    frame_o.rtr  = word_i[RTR_BIT];
    frame_o.dlc  = word_i[DLC_LSB +: DLC_W];
    frame_o.rsvd = word_i[RSVD_LSB +: RSVD_W];
    frame_o.data = word_i[DATA_LSB +: DATA_W];
    if (frame_o.dlc > DLC_W'(DLC_MAX)) begin
      frame_o.dlc = DLC_W'(DLC_MAX);
    end
  end

endmodule

// File: rtl/can_tx_frame_fetch.sv
// Tx FIFO read client: pops one frame, offers it to the bit engine, holds it until done/abort/retry limit.
module can_tx_frame_fetch
  import can_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned MAX_RETRIES = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_fifo_r_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_r_en,
  output logic                  o_frame_valid,
  input  logic                  i_tx_ready,
  output logic [ID_W-1:0]       o_id,
  output logic                  o_ide,
  output logic                  o_rtr,
  output logic [DLC_W-1:0]      o_dlc,
  output logic [DATA_W-1:0]     o_data,
  input  logic                  i_tx_done,
  input  logic                  i_tx_arb_lost,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_tx_fail,
  output logic [CNT_WIDTH-1:0]  o_frames_sent
);

  localparam int unsigned RETRY_W = 8;

  tx_fetch_state_t      state_q, state_d;
  can_frame_t           frame_q, frame_d;
  can_frame_t           word_frame;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [CNT_WIDTH-1:0] sent_q, sent_d;
  logic                 r_en_q, r_en_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 fail_q, fail_d;
  logic                 unused_rsvd;

  can_frame_unpack u_unpack (
    .word_i  (i_fifo_r_data[CAN_FRAME_W-1:0]),
    .frame_o (word_frame)
  );

  // State, frame hold register, counters and registered outputs.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      retry_q <= '0;
      sent_q  <= '0;
      r_en_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      retry_q <= retry_d;
      sent_q  <= sent_d;
      r_en_q  <= r_en_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic; abort beats done, done beats arbitration loss.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    retry_d = retry_q;
    sent_d  = sent_q;
    fail_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!i_fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        frame_d = word_frame;
        retry_d = '0;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (i_abort) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (i_tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_abort) begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (i_tx_done) begin
          if (sent_q != '1) sent_d = sent_q + CNT_WIDTH'(1);
          state_d = ST_IDLE;
        end else if (i_tx_arb_lost) begin
          if (retry_q < RETRY_W'(MAX_RETRIES)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_OFFER;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    r_en_d  = (state_d == ST_POP);
    valid_d = (state_d == ST_OFFER);
    busy_d  = (state_d != ST_IDLE);
  end

  // Reserved bits travel with the frame but have no consumer here.
  assign unused_rsvd = ^frame_q.rsvd;

  assign o_fifo_r_en   = r_en_q;
  assign o_frame_valid = valid_q;
  assign o_busy        = busy_q;
  assign o_tx_fail     = fail_q;
  assign o_frames_sent = sent_q;
  assign o_id          = frame_q.id;
  assign o_ide         = frame_q.ide;
  assign o_rtr         = frame_q.rtr;
  assign o_dlc         = frame_q.dlc;
  assign o_data        = frame_q.data;

endmodule

// File: tb/tb_can_tx_frame_fetch.sv
// Directed bench for can_tx_frame_fetch with a small FIFO model on the read port.
module tb_can_tx_frame_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] fifo_r_data = '0;
  logic         fifo_empty;
  logic         fifo_r_en;
  logic         frame_valid;
  logic         tx_ready = 1'b0;
  logic [28:0]  id;
  logic         ide;
  logic         rtr;
  logic [3:0]   dlc;
  logic [63:0]  data;
  logic         tx_done = 1'b0;
  logic         tx_arb_lost = 1'b0;
  logic         abort = 1'b0;
  logic         busy;
  logic         tx_fail;
  logic [15:0]  frames_sent;

  logic [127:0] mem [16];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           pop_cnt = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           base;

  always #5 clk = ~clk;

  can_tx_frame_fetch #(.DATA_WIDTH(128), .MAX_RETRIES(2), .CNT_WIDTH(16)) dut (
    .i_sys_clk     (clk),
    .i_reset_n     (rst_n),
    .i_fifo_r_data (fifo_r_data),
    .i_fifo_empty  (fifo_empty),
    .o_fifo_r_en   (fifo_r_en),
    .o_frame_valid (frame_valid),
    .i_tx_ready    (tx_ready),
    .o_id          (id),
    .o_ide         (ide),
    .o_rtr         (rtr),
    .o_dlc         (dlc),
    .o_data        (data),
    .i_tx_done     (tx_done),
    .i_tx_arb_lost (tx_arb_lost),
    .i_abort       (abort),
    .o_busy        (busy),
    .o_tx_fail     (tx_fail),
    .o_frames_sent (frames_sent)
  );

  // FIFO model: read data appears the cycle after the strobe.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_r_data <= mem[rd_ptr % 16];
      rd_ptr      <= rd_ptr + 1;
      pop_cnt     <= pop_cnt + 1;
    end
  end

  function automatic logic [127:0] mk_word(input logic [28:0] f_id, input logic f_ide,
                                           input logic f_rtr, input logic [3:0] f_dlc,
                                           input logic [63:0] f_data);
    return {f_id, f_ide, f_rtr, f_dlc, 29'h15A5_A5A5, f_data};
  endfunction

  task automatic push(input logic [127:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_r_en(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (fifo_r_en) break;
      tick();
    end
    chk(tag, 64'(fifo_r_en), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (frame_valid) break;
      tick();
    end
    chk(tag, 64'(frame_valid), 64'd1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic accept();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_r_en", 64'(fifo_r_en), 64'd0);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fail", 64'(tx_fail), 64'd0);
    chk("rst_sent", 64'(frames_sent), 64'd0);
    chk("rst_id", 64'(id), 64'd0);
    chk("rst_data", data, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Single frame with latency check
    push(mk_word(29'h123, 1'b0, 1'b0, 4'd2, 64'hABCD_1234_5678_9ABC));
    wait_r_en("s_pop");
    chk("s_pop_busy", 64'(busy), 64'd1);
    tick();
    chk("s_cap_r_en", 64'(fifo_r_en), 64'd0);
    chk("s_cap_valid", 64'(frame_valid), 64'd0);
    tick();
    chk("s_offer_valid", 64'(frame_valid), 64'd1);
    chk("s_id", 64'(id), 64'h123);
    chk("s_ide", 64'(ide), 64'd0);
    chk("s_rtr", 64'(rtr), 64'd0);
    chk("s_dlc", 64'(dlc), 64'd2);
    chk("s_data", data, 64'hABCD_1234_5678_9ABC);
    tick();
    chk("s_hold_valid", 64'(frame_valid), 64'd1);
    accept();
    chk("s_wait_valid", 64'(frame_valid), 64'd0);
    chk("s_wait_busy", 64'(busy), 64'd1);
    pulse_done();
    chk("s_sent", 64'(frames_sent), 64'd1);
    chk("s_busy", 64'(busy), 64'd0);
    chk("s_pops", 64'(pop_cnt), 64'd1);

    // Done / arb_lost while idle are ignored
    pulse_done();
    tx_arb_lost = 1'b1;
    tick();
    tx_arb_lost = 1'b0;
    chk("idle_done_sent", 64'(frames_sent), 64'd1);
    chk("idle_arb_fail", 64'(tx_fail), 64'd0);

    // DLC clamp, extended remote frame
    push(mk_word(29'h1ABC_DEF5, 1'b1, 1'b1, 4'hF, 64'h0123_4567_89AB_CDEF));
    wait_r_en("c_pop");
    tick();
    tick();
    chk("c_valid", 64'(frame_valid), 64'd1);
    chk("c_dlc", 64'(dlc), 64'd8);
    chk("c_data", data, 64'h0123_4567_89AB_CDEF);
    chk("c_id", 64'(id), 64'h1ABC_DEF5);
    chk("c_ide", 64'(ide), 64'd1);
    chk("c_rtr", 64'(rtr), 64'd1);
    accept();
    pulse_done();
    chk("c_sent", 64'(frames_sent), 64'd2);

    // Arbitration retry: two re-offers then failure
    push(mk_word(29'h0A5, 1'b0, 1'b0, 4'd8, 64'hFEED_FACE_CAFE_BEEF));
    wait_r_en("r_pop");
    tick();
    tick();
    chk("r_valid0", 64'(frame_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      accept();
      chk("r_wait_valid", 64'(frame_valid), 64'd0);
      tx_arb_lost = 1'b1;
      tick();
      tx_arb_lost = 1'b0;
      if (k < 2) begin
        chk("r_reoffer_valid", 64'(frame_valid), 64'd1);
        chk("r_reoffer_id", 64'(id), 64'h0A5);
        chk("r_reoffer_data", data, 64'hFEED_FACE_CAFE_BEEF);
        chk("r_reoffer_fail", 64'(tx_fail), 64'd0);
      end else begin
        chk("r_fail", 64'(tx_fail), 64'd1);
        chk("r_fail_busy", 64'(busy), 64'd0);
        chk("r_fail_valid", 64'(frame_valid), 64'd0);
      end
    end
    tick();
    chk("r_fail_pulse", 64'(tx_fail), 64'd0);
    chk("r_sent", 64'(frames_sent), 64'd2);
    chk("r_pops", 64'(pop_cnt), 64'd3);

    // Done and arb_lost together count as sent
    push(mk_word(29'h0BB, 1'b0, 1'b0, 4'd1, 64'h11));
    wait_r_en("x_pop");
    tick();
    tick();
    accept();
    tx_done = 1'b1;
    tx_arb_lost = 1'b1;
    tick();
    tx_done = 1'b0;
    tx_arb_lost = 1'b0;
    chk("x_sent", 64'(frames_sent), 64'd3);
    chk("x_busy", 64'(busy), 64'd0);
    chk("x_fail", 64'(tx_fail), 64'd0);

    // Back-to-back: three frames, ready tied high, done 5 cycles after acceptance
    base = pop_cnt;
    for (int i = 0; i < 3; i++) push(mk_word(29'(32'h10 + i), 1'b0, 1'b0, 4'd4, 64'(i)));
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid("b_valid");
      chk("b_id", 64'(id), 64'h10 + 64'(i));
      tick();
      chk("b_accepted", 64'(frame_valid), 64'd0);
      repeat (4) tick();
      pulse_done();
    end
    tx_ready = 1'b0;
    repeat (3) tick();
    chk("b_pops", 64'(pop_cnt - base), 64'd3);
    chk("b_sent", 64'(frames_sent), 64'd6);

    // Abort in OFFER, then abort beating done in WAIT_DONE
    push(mk_word(29'h20, 1'b0, 1'b0, 4'd3, 64'h20));
    push(mk_word(29'h21, 1'b0, 1'b0, 4'd3, 64'h21));
    wait_valid("a_valid0");
    chk("a_id0", 64'(id), 64'h20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_fail", 64'(tx_fail), 64'd1);
    chk("a_valid_drop", 64'(frame_valid), 64'd0);
    chk("a_busy", 64'(busy), 64'd0);
    wait_valid("a_valid1");
    chk("a_id1", 64'(id), 64'h21);
    accept();
    abort = 1'b1;
    tx_done = 1'b1;
    tick();
    abort = 1'b0;
    tx_done = 1'b0;
    chk("a_win_fail", 64'(tx_fail), 64'd1);
    chk("a_win_sent", 64'(frames_sent), 64'd6);

    // Async reset during WAIT_DONE with a frame still queued
    push(mk_word(29'h30, 1'b0, 1'b0, 4'd5, 64'h30));
    push(mk_word(29'h31, 1'b0, 1'b0, 4'd5, 64'h31));
    wait_valid("z_valid0");
    accept();
    chk("z_wait_busy", 64'(busy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("z_rst_busy", 64'(busy), 64'd0);
    chk("z_rst_valid", 64'(frame_valid), 64'd0);
    chk("z_rst_sent", 64'(frames_sent), 64'd0);
    chk("z_rst_id", 64'(id), 64'd0);
    base = pop_cnt;
    repeat (3) tick();
    chk("z_rst_r_en", 64'(fifo_r_en), 64'd0);
    chk("z_rst_pops", 64'(pop_cnt - base), 64'd0);
    rst_n = 1'b1;
    wait_r_en("z_pop");
    tick();
    tick();
    chk("z_valid1", 64'(frame_valid), 64'd1);
    chk("z_id1", 64'(id), 64'h31);
    accept();
    pulse_done();
    chk("z_sent", 64'(frames_sent), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
